pcileech_ft601_rx_decode: RTL and testbench



---
 rtl/pcileech_ft601_rx_decode.sv | 221 ++++++++++++++++++++++
 tb/tb_pcileech_ft601_rx_decode.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_ft601_rx_decode.sv
// pcileech_ft601_rx_decode
//   Receive-side command decoder for the FT601 RX word stream. Incoming 32-bit
//   words are paired into 64-bit commands {header, payload}. A header whose
//   top byte is 8'h77 is steered by its type field to the TLP queue, the CFG
//   queue or the loopback strobe. The FT601 side cannot be stalled, so each
//   queue drops commands on overflow and drops are counted.
//
// Ports
//   clk_i         FT601 clock, all logic on the rising edge
//   rst_ni        asynchronous active-low reset
//   rx_data_i     32-bit word from the FT601 controller
//   rx_wren_i     rx_data_i valid this cycle (no backpressure)
//   tlp_data_o    [31:0] payload, [32] first, [33] last
//   tlp_valid_o   tlp_data_o valid
//   tlp_ready_i   TLP consumer accepts on valid & ready
//   cfg_data_o    {header, payload}
//   cfg_valid_o   cfg_data_o valid
//   cfg_ready_i   CFG consumer accepts on valid & ready
//   loop_data_o   loopback payload
//   loop_valid_o  one-cycle loopback strobe
//   drop_cnt_o    saturating count of commands dropped on overflow
//   err_magic_o   one-cycle pulse on a header with a bad magic byte

// First-word-fall-through queue with a registered output stage.
// Occupancy includes the output register, so DEPTH entries are held in total.
module pcileech_ft601_rx_decode_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   occ;
    logic [W-1:0]  out_q;
    logic          out_vld_q;
    logic          pop, full, wr, load;

    assign pop  = out_vld_q & ready_i;
    assign occ  = cnt_q + {{AW{1'b0}}, out_vld_q};
    assign full = (occ == (AW+1)'(DEPTH));
    // A push into a full queue is accepted when the same cycle frees a slot.
    assign wr     = push_i & (~full | pop);
    assign drop_o = push_i & full & ~pop;
    // Refill the output register whenever it is empty or being consumed.
    assign load = (cnt_q != '0) & (~out_vld_q | pop);

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (wr)   wptr_q <= wptr_q + 1'b1;
            if (load) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, load};
            if (load) begin
                out_q     <= mem_q[rptr_q];
                out_vld_q <= 1'b1;
            end else if (pop) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign data_o  = out_q;
    assign valid_o = out_vld_q;
endmodule

module pcileech_ft601_rx_decode #(
    parameter int TLP_DEPTH   = 16,
    parameter int CFG_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] rx_data_i,
    input  logic        rx_wren_i,
    output logic [33:0] tlp_data_o,
    output logic        tlp_valid_o,
    input  logic        tlp_ready_i,
    output logic [63:0] cfg_data_o,
    output logic        cfg_valid_o,
    input  logic        cfg_ready_i,
    output logic [31:0] loop_data_o,
    output logic        loop_valid_o,
    output logic [15:0] drop_cnt_o,
    output logic        err_magic_o
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {IDLE, HAVE_LO} state_t;

    state_t        state_q, state_d;
    logic [31:0]   lo_q, lo_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          dec_tlp_q, dec_tlp_d;
    logic          dec_cfg_q, dec_cfg_d;
    logic          dec_loop_q, dec_loop_d;
    logic [31:0]   dec_hdr_q, dec_lo_q;
    logic          loop_vld_q;
    logic [31:0]   loop_data_q;
    logic [15:0]   drop_q;
    logic          tlp_drop, cfg_drop;

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        tmo_d      = tmo_q;
        err_d      = 1'b0;
        dec_tlp_d  = 1'b0;
        dec_cfg_d  = 1'b0;
        dec_loop_d = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (rx_wren_i) begin
                    lo_d    = rx_data_i;
                    state_d = HAVE_LO;
                end
            end
            HAVE_LO: begin
                if (rx_wren_i) begin
                    tmo_d = '0;
                    if (rx_data_i[31:24] == 8'h77) begin
                        state_d    = IDLE;
                        // Unknown types are legal headers: consumed, not counted.
                        dec_tlp_d  = (rx_data_i[19:16] == 4'h1);
                        dec_cfg_d  = (rx_data_i[19:16] == 4'h3);
                        dec_loop_d = (rx_data_i[19:16] == 4'h4);
                    end else begin
                        // Resync by one word: the bad header becomes the new LO.
                        err_d = 1'b1;
                        lo_d  = rx_data_i;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            dec_tlp_q   <= 1'b0;
            dec_cfg_q   <= 1'b0;
            dec_loop_q  <= 1'b0;
            dec_hdr_q   <= '0;
            dec_lo_q    <= '0;
            loop_vld_q  <= 1'b0;
            loop_data_q <= '0;
            drop_q      <= '0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            dec_tlp_q  <= dec_tlp_d;
            dec_cfg_q  <= dec_cfg_d;
            dec_loop_q <= dec_loop_d;
            dec_hdr_q  <= rx_data_i;
            dec_lo_q   <= lo_q;
            loop_vld_q <= dec_loop_q;
            if (dec_loop_q) loop_data_q <= dec_lo_q;
            // At most one queue is pushed per cycle, so one increment suffices.
            if ((tlp_drop | cfg_drop) && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
        end
    end

    pcileech_ft601_rx_decode_fifo #(.W(34), .DEPTH(TLP_DEPTH)) u_tlp_q (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (dec_tlp_q),
        .push_data_i ({dec_hdr_q[1], dec_hdr_q[0], dec_lo_q}),
        .ready_i     (tlp_ready_i),
        .data_o      (tlp_data_o),
        .valid_o     (tlp_valid_o),
        .drop_o      (tlp_drop)
    );

    pcileech_ft601_rx_decode_fifo #(.W(64), .DEPTH(CFG_DEPTH)) u_cfg_q (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (dec_cfg_q),
        .push_data_i ({dec_hdr_q, dec_lo_q}),
        .ready_i     (cfg_ready_i),
        .data_o      (cfg_data_o),
        .valid_o     (cfg_valid_o),
        .drop_o      (cfg_drop)
    );

    assign loop_data_o  = loop_data_q;
    assign loop_valid_o = loop_vld_q;
    assign drop_cnt_o   = drop_q;
    assign err_magic_o  = err_q;
endmodule

// File: tb/tb_pcileech_ft601_rx_decode.sv
module tb_pcileech_ft601_rx_decode;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rx_data;
    logic        rx_wren;
    logic [33:0] tlp_data;
    logic        tlp_valid;
    logic        tlp_ready;
    logic [63:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] loop_data;
    logic        loop_valid;
    logic [15:0] drop_cnt;
    logic        err_magic;

    int n_chk  = 0;
    int n_fail = 0;
    int err_pulses = 0;

    always #5 clk = ~clk;

    pcileech_ft601_rx_decode #(.TLP_DEPTH(16), .CFG_DEPTH(4), .TIMEOUT_CYC(1024)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_data_i    (rx_data),
        .rx_wren_i    (rx_wren),
        .tlp_data_o   (tlp_data),
        .tlp_valid_o  (tlp_valid),
        .tlp_ready_i  (tlp_ready),
        .cfg_data_o   (cfg_data),
        .cfg_valid_o  (cfg_valid),
        .cfg_ready_i  (cfg_ready),
        .loop_data_o  (loop_data),
        .loop_valid_o (loop_valid),
        .drop_cnt_o   (drop_cnt),
        .err_magic_o  (err_magic)
    );

    always @(negedge clk) if (err_magic) err_pulses++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one word so that it is sampled at the next rising edge.
    task automatic put(input logic [31:0] w);
        @(negedge clk);
        rx_data = w;
        rx_wren = 1'b1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_wren = 1'b0;
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hdr;
        logic        exp_tlp;
        logic [33:0] tlp_d;
        logic        exp_cfg;
        logic [63:0] cfg_d;
        logic        exp_loop;
        logic [31:0] loop_d;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int beats;
        int e0;

        vecs[0] = '{32'hDEADBEEF, 32'h7701_0003, 1'b1, {2'b11, 32'hDEADBEEF}, 1'b0, 64'h0, 1'b0, 32'h0};
        vecs[1] = '{32'h0000_0011, 32'h7701_0001, 1'b1, {2'b01, 32'h0000_0011}, 1'b0, 64'h0, 1'b0, 32'h0};
        vecs[2] = '{32'h0000_0022, 32'h7701_0002, 1'b1, {2'b10, 32'h0000_0022}, 1'b0, 64'h0, 1'b0, 32'h0};
        vecs[3] = '{32'hCAFEF00D, 32'h7703_ABCD, 1'b0, 34'h0, 1'b1, 64'h7703ABCD_CAFEF00D, 1'b0, 32'h0};
        vecs[4] = '{32'h1357_9BDF, 32'h7704_0000, 1'b0, 34'h0, 1'b0, 64'h0, 1'b1, 32'h1357_9BDF};
        vecs[5] = '{32'h0000_1234, 32'h7702_0000, 1'b0, 34'h0, 1'b0, 64'h0, 1'b0, 32'h0};

        rst_n = 1'b0; rx_data = '0; rx_wren = 1'b0; tlp_ready = 1'b1; cfg_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_tlp_valid", 64'(tlp_valid), 64'd0);
        chk("rst_cfg_valid", 64'(cfg_valid), 64'd0);
        chk("rst_loop_valid", 64'(loop_valid), 64'd0);
        chk("rst_err", 64'(err_magic), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Table-driven single commands with both consumers ready.
        for (int i = 0; i < 6; i++) begin
            put(vecs[i].lo);
            put(vecs[i].hdr);
            idle(1);
            chk($sformatf("v%0d_err", i), 64'(err_magic), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_loop_valid", i), 64'(loop_valid), 64'(vecs[i].exp_loop));
            if (vecs[i].exp_loop) chk($sformatf("v%0d_loop_data", i), 64'(loop_data), 64'(vecs[i].loop_d));
            @(negedge clk);
            chk($sformatf("v%0d_loop_off", i), 64'(loop_valid), 64'd0);
            chk($sformatf("v%0d_tlp_valid", i), 64'(tlp_valid), 64'(vecs[i].exp_tlp));
            chk($sformatf("v%0d_cfg_valid", i), 64'(cfg_valid), 64'(vecs[i].exp_cfg));
            if (vecs[i].exp_tlp) chk($sformatf("v%0d_tlp_data", i), 64'(tlp_data), 64'(vecs[i].tlp_d));
            if (vecs[i].exp_cfg) chk($sformatf("v%0d_cfg_data", i), cfg_data, vecs[i].cfg_d);
            @(negedge clk);
            chk($sformatf("v%0d_tlp_done", i), 64'(tlp_valid), 64'd0);
            chk($sformatf("v%0d_cfg_done", i), 64'(cfg_valid), 64'd0);
        end
        chk("table_drop", 64'(drop_cnt), 64'd0);
        chk("table_err_pulses", 64'(err_pulses), 64'd0);

        // Bad magic resync: the zero word becomes LO, 0x12345678 is lost.
        e0 = err_pulses;
        put(32'h1234_5678);
        put(32'h0000_0000);
        put(32'h7703_0000);
        idle(3);
        chk("resync_cfg_valid", 64'(cfg_valid), 64'd1);
        chk("resync_cfg_data", cfg_data, 64'h7703_0000_0000_0000);
        chk("resync_tlp_valid", 64'(tlp_valid), 64'd0);
        chk("resync_err_pulses", 64'(err_pulses - e0), 64'd1);
        idle(2);
        chk("resync_cfg_done", 64'(cfg_valid), 64'd0);

        // Timeout discards a lone LO; the next pair decodes cleanly.
        e0 = err_pulses;
        put(32'hAAAA_AAAA);
        idle(1024);
        put(32'h5555_5555);
        put(32'h7704_0000);
        idle(2);
        chk("tmo_loop_valid", 64'(loop_valid), 64'd1);
        chk("tmo_loop_data", 64'(loop_data), 64'h5555_5555);
        @(negedge clk);
        chk("tmo_loop_off", 64'(loop_valid), 64'd0);
        chk("tmo_err_pulses", 64'(err_pulses - e0), 64'd0);

        // TLP overflow: 18 commands into 16 entries, then drain in order.
        tlp_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            put(32'(i) + 32'h100);
            put(32'h7701_0003);
        end
        idle(4);
        chk("ovf_drop", 64'(drop_cnt), 64'd2);
        chk("ovf_hold_valid", 64'(tlp_valid), 64'd1);
        chk("ovf_hold_data", 64'(tlp_data), 64'({2'b11, 32'h100}));
        tlp_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 40; c++) begin
            if (tlp_valid) begin
                chk($sformatf("ovf_beat%0d", beats), 64'(tlp_data), 64'({2'b11, 32'(beats) + 32'h100}));
                beats++;
            end
            @(negedge clk);
        end
        chk("ovf_beats", 64'(beats), 64'd16);

        // Reset with a held LO and three CFG entries queued.
        cfg_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(32'h0000_0A00 + 32'(i));
            put(32'h7703_0000 + 32'(i));
        end
        idle(4);
        chk("pre_rst_cfg_valid", 64'(cfg_valid), 64'd1);
        put(32'h0000_0001);
        @(negedge clk);
        rx_wren = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_cfg_valid", 64'(cfg_valid), 64'd0);
        chk("post_rst_drop", 64'(drop_cnt), 64'd2 - 64'd2);
        put(32'hBEEF_0001);
        put(32'h7703_0055);
        idle(4);
        chk("post_rst_new_valid", 64'(cfg_valid), 64'd1);
        chk("post_rst_new_data", cfg_data, 64'h7703_0055_BEEF_0001);
        cfg_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_only_one", 64'(cfg_valid), 64'd0);

        // Drop counter accumulation and saturation.
        tlp_ready = 1'b0;
        for (int i = 0; i < 316; i++) begin
            put(32'(i));
            put(32'h7701_0000);
        end
        idle(4);
        chk("acc_drop", 64'(drop_cnt), 64'd300);
        force dut.drop_q = 16'hFFFD;
        @(negedge clk);
        release dut.drop_q;
        for (int i = 0; i < 5; i++) begin
            put(32'(i));
            put(32'h7701_0000);
        end
        idle(4);
        chk("sat_drop", 64'(drop_cnt), 64'hFFFF);
        chk("sat_head", 64'(tlp_data), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
